// File: rtl/global_buffer_pingpong.sv
// Two-bank ping-pong buffer: producer fills one bank while consumer drains the other.
// Read latency READ_LAT (1 or 2) cycles; readiness comes from per-bank EMPTY/FULL status.
module global_buffer_pingpong #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 32,
   parameter int READ_LAT  = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic [ADDR_BITS-1:0]   i_wr_index,
   input  logic [DATA_BITS-1:0]   i_wr_data,
   input  logic [DATA_BITS/8-1:0] i_wr_strb,
   input  logic                   i_wr_done,
   output logic                   o_wr_ready,
   output logic                   o_wr_bank,
   input  logic                   i_rd_en,
   input  logic [ADDR_BITS-1:0]   i_rd_index,
   input  logic                   i_rd_done,
   output logic                   o_rd_ready,
   output logic                   o_rd_bank,
   output logic [DATA_BITS-1:0]   o_rd_data,
   output logic                   o_rd_valid,
   output logic                   o_wr_err,
   output logic                   o_rd_err
);

   localparam int DEPTH     = 1 << ADDR_BITS;
   localparam int STRB_BITS = DATA_BITS / 8;

   logic [1:0]           r_status;
   logic                 r_wbank;
   logic                 r_rbank;
   logic                 r_wr_err;
   logic                 r_rd_err;
   logic                 r_rd_v1;
   logic                 r_rd_sel;
   logic                 r_rd_seen;
   logic                 w_wr_ready;
   logic                 w_rd_ready;
   logic                 w_wr_fire;
   logic                 w_rd_fire;
   logic                 w_wr_close;
   logic                 w_rd_close;
   logic [DATA_BITS-1:0] w_rd_q;
   logic [DATA_BITS-1:0] w_bank_q [2];

   assign w_wr_ready = ~r_status[r_wbank];
   assign w_rd_ready = r_status[r_rbank];
   assign w_wr_fire  = i_wr_en   & w_wr_ready;
   assign w_rd_fire  = i_rd_en   & w_rd_ready;
   assign w_wr_close = i_wr_done & w_wr_ready;
   assign w_rd_close = i_rd_done & w_rd_ready;

   // The two closes always target different banks (one needs EMPTY, the other FULL).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_status <= 2'b00;
         r_wbank  <= 1'b0;
         r_rbank  <= 1'b0;
         r_wr_err <= 1'b0;
         r_rd_err <= 1'b0;
      end else begin
         if (w_wr_close) begin
            r_status[r_wbank] <= 1'b1;
            r_wbank           <= ~r_wbank;
         end
         if (w_rd_close) begin
            r_status[r_rbank] <= 1'b0;
            r_rbank           <= ~r_rbank;
         end
         if ((i_wr_en | i_wr_done) & ~w_wr_ready) r_wr_err <= 1'b1;
         if ((i_rd_en | i_rd_done) & ~w_rd_ready) r_rd_err <= 1'b1;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      (* ram_style = "block" *) logic [DATA_BITS-1:0] r_mem [DEPTH];
      logic [DATA_BITS-1:0] r_q;

      always_ff @(posedge i_clk) begin
         for (int k = 0; k < STRB_BITS; k++) begin
            if (w_wr_fire && (r_wbank == 1'(b)) && i_wr_strb[k])
               r_mem[i_wr_index][8*k +: 8] <= i_wr_data[8*k +: 8];
         end
         if (w_rd_fire && (r_rbank == 1'(b)))
            r_q <= r_mem[i_rd_index];
      end

      assign w_bank_q[b] = r_q;
   end

   // RAM output registers carry no reset; r_rd_seen masks them to zero until the first read.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_v1   <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_rd_seen <= 1'b0;
      end else begin
         r_rd_v1 <= w_rd_fire;
         if (w_rd_fire) begin
            r_rd_sel  <= r_rbank;
            r_rd_seen <= 1'b1;
         end
      end
   end

   assign w_rd_q = r_rd_seen ? w_bank_q[r_rd_sel] : '0;

   if (READ_LAT == 2) begin : g_lat2
      logic                 r_rd_v2;
      logic [DATA_BITS-1:0] r_rd_d2;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_rd_v2 <= 1'b0;
            r_rd_d2 <= '0;
         end else begin
            r_rd_v2 <= r_rd_v1;
            if (r_rd_v1) r_rd_d2 <= w_rd_q;
         end
      end

      assign o_rd_valid = r_rd_v2;
      assign o_rd_data  = r_rd_d2;
   end else begin : g_lat1
      assign o_rd_valid = r_rd_v1;
      assign o_rd_data  = w_rd_q;
   end

   assign o_wr_ready = w_wr_ready;
   assign o_rd_ready = w_rd_ready;
   assign o_wr_bank  = r_wbank;
   assign o_rd_bank  = r_rbank;
   assign o_wr_err   = r_wr_err;
   assign o_rd_err   = r_rd_err;

endmodule

// File: tb/tb_global_buffer_pingpong.sv
// Directed bench: two instances (READ_LAT=1 and READ_LAT=2) driven by identical stimulus.
module tb_global_buffer_pingpong;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [7:0]  wr_index;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_done;
   logic        rd_en;
   logic [7:0]  rd_index;
   logic        rd_done;

   logic        wr_ready1, wr_bank1, rd_ready1, rd_bank1, rd_valid1, wr_err1, rd_err1;
   logic [31:0] rd_data1;
   logic        wr_ready2, wr_bank2, rd_ready2, rd_bank2, rd_valid2, wr_err2, rd_err2;
   logic [31:0] rd_data2;

   int n_vec;
   int n_err;

   global_buffer_pingpong #(.ADDR_BITS(8), .DATA_BITS(32), .READ_LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_wr_en(wr_en), .i_wr_index(wr_index), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
      .i_wr_done(wr_done), .o_wr_ready(wr_ready1), .o_wr_bank(wr_bank1),
      .i_rd_en(rd_en), .i_rd_index(rd_index), .i_rd_done(rd_done),
      .o_rd_ready(rd_ready1), .o_rd_bank(rd_bank1), .o_rd_data(rd_data1),
      .o_rd_valid(rd_valid1), .o_wr_err(wr_err1), .o_rd_err(rd_err1)
   );

   global_buffer_pingpong #(.ADDR_BITS(8), .DATA_BITS(32), .READ_LAT(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst),
      .i_wr_en(wr_en), .i_wr_index(wr_index), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
      .i_wr_done(wr_done), .o_wr_ready(wr_ready2), .o_wr_bank(wr_bank2),
      .i_rd_en(rd_en), .i_rd_index(rd_index), .i_rd_done(rd_done),
      .o_rd_ready(rd_ready2), .o_rd_bank(rd_bank2), .o_rd_data(rd_data2),
      .o_rd_valid(rd_valid2), .o_wr_err(wr_err2), .o_rd_err(rd_err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] pat1(input int i);
      logic [7:0] x;
      x = 8'(i);
      return {8'hB1, x, ~x, x ^ 8'h5A};
   endfunction

   function automatic logic [31:0] pat0(input int i);
      logic [7:0] x;
      x = 8'(i);
      return {8'hC0, x ^ 8'hA5, x, ~x};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_index = '0; wr_data = '0; wr_strb = '0; wr_done = 1'b0;
      rd_en = 1'b0; rd_index = '0; rd_done = 1'b0;
   endtask

   task automatic write(input int idx, input logic [31:0] d, input logic [3:0] s, input logic done);
      wr_en = 1'b1; wr_index = 8'(idx); wr_data = d; wr_strb = s; wr_done = done;
   endtask

   task automatic read(input int idx);
      rd_en = 1'b1; rd_index = 8'(idx);
   endtask

   task automatic check_flags(input string tag, input logic wrdy, input logic wb,
                              input logic rrdy, input logic rb, input logic we, input logic re);
      check({tag, "_wr_ready"}, 32'(wr_ready1), 32'(wrdy));
      check({tag, "_wr_bank"},  32'(wr_bank1),  32'(wb));
      check({tag, "_rd_ready"}, 32'(rd_ready1), 32'(rrdy));
      check({tag, "_rd_bank"},  32'(rd_bank1),  32'(rb));
      check({tag, "_wr_err"},   32'(wr_err1),   32'(we));
      check({tag, "_rd_err"},   32'(rd_err1),   32'(re));
      check({tag, "_lat2_state"}, {26'd0, wr_ready2, wr_bank2, rd_ready2, rd_bank2, wr_err2, rd_err2},
            {26'd0, wrdy, wb, rrdy, rb, we, re});
   endtask

   int rd_list [4] = '{7, 8, 9, 255};

   initial begin
      n_vec = 0;
      n_err = 0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_valid1", 32'(rd_valid1), 32'd0);
      check("reset_data1", rd_data1, 32'd0);
      check("reset_valid2", 32'(rd_valid2), 32'd0);
      check("reset_data2", rd_data2, 32'd0);
      rst = 1'b0;

      // read with both banks EMPTY
      read(0);
      tick();
      idle();
      check_flags("rd_empty", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rd_empty_valid1", 32'(rd_valid1), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rd_err_cleared", 32'(rd_err1), 32'd0);

      // full and partial writes into bank0, then close it
      write(5, 32'h11223344, 4'hF, 1'b0);
      tick();
      write(3, 32'hAABBCCDD, 4'hF, 1'b0);
      tick();
      write(3, 32'h00000000, 4'b0101, 1'b0);
      tick();
      idle();
      wr_done = 1'b1;
      tick();
      idle();
      check_flags("close0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      read(5);
      tick();
      check("t1_valid1", 32'(rd_valid1), 32'd1);
      check("t1_data1", rd_data1, 32'h11223344);
      check("t1_valid2_early", 32'(rd_valid2), 32'd0);
      read(3);
      tick();
      idle();
      check("t2_valid1", 32'(rd_valid1), 32'd1);
      check("t2_data1", rd_data1, 32'hAA00CC00);
      check("t1_valid2", 32'(rd_valid2), 32'd1);
      check("t1_data2", rd_data2, 32'h11223344);
      tick();
      check("t2_hold_valid1", 32'(rd_valid1), 32'd0);
      check("t2_hold_data1", rd_data1, 32'hAA00CC00);
      check("t2_valid2", 32'(rd_valid2), 32'd1);
      check("t2_data2", rd_data2, 32'hAA00CC00);
      tick();
      check("t2_idle_valid2", 32'(rd_valid2), 32'd0);
      check("t2_hold_data2", rd_data2, 32'hAA00CC00);

      // fill bank1; last write shares the cycle with wr_done
      for (int i = 0; i < 256; i++) begin
         write(i, pat1(i), 4'hF, i == 255);
         tick();
      end
      idle();
      check_flags("both_full", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rd_done = 1'b1;
      tick();
      idle();
      check_flags("drop0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // write bank0 while reading bank1 back-to-back; both done on the final cycle
      for (int i = 0; i < 256; i++) begin
         write(i, pat0(i), 4'hF, i == 255);
         read(i);
         rd_done = (i == 255);
         tick();
         check("pp_valid1", 32'(rd_valid1), 32'd1);
         check("pp_data1", rd_data1, pat1(i));
         if (i > 0) begin
            check("pp_valid2", 32'(rd_valid2), 32'd1);
            check("pp_data2", rd_data2, pat1(i - 1));
         end
      end
      idle();
      tick();
      check("pp_end_valid1", 32'(rd_valid1), 32'd0);
      check("pp_end_valid2", 32'(rd_valid2), 32'd1);
      check("pp_end_data2", rd_data2, pat1(255));
      check_flags("swap", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // back-to-back reads of bank0, including the entry written with wr_done
      for (int j = 0; j < 4; j++) begin
         read(rd_list[j]);
         tick();
         check("b2b_valid1", 32'(rd_valid1), 32'd1);
         check("b2b_data1", rd_data1, pat0(rd_list[j]));
         check("b2b_valid2", 32'(rd_valid2), 32'(j >= 1));
         if (j >= 1) check("b2b_data2", rd_data2, pat0(rd_list[j - 1]));
      end
      idle();
      tick();
      check("b2b_tail_valid1", 32'(rd_valid1), 32'd0);
      check("b2b_tail_valid2", 32'(rd_valid2), 32'd1);
      check("b2b_tail_data2", rd_data2, pat0(255));
      tick();
      check("b2b_done_valid2", 32'(rd_valid2), 32'd0);
      check("b2b_done_data2", rd_data2, pat0(255));

      // both FULL: an extra write is dropped and flagged
      write(0, 32'hDEADBEEF, 4'hF, 1'b1);
      tick();
      idle();
      check_flags("full2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      write(7, 32'h12345678, 4'hF, 1'b0);
      tick();
      idle();
      check_flags("wr_blocked", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      read(7);
      tick();
      idle();
      check("blocked_valid1", 32'(rd_valid1), 32'd1);
      check("blocked_data1", rd_data1, pat0(7));
      tick();
      check("blocked_data2", rd_data2, pat0(7));

      // reset with a read in flight and wr_bank=1
      rd_done = 1'b1;
      tick();
      idle();
      wr_done = 1'b1;
      tick();
      idle();
      check_flags("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      read(0);
      tick();
      idle();
      check("inflight_valid1", 32'(rd_valid1), 32'd1);
      check("inflight_data1", rd_data1, 32'hDEADBEEF);
      check("inflight_valid2", 32'(rd_valid2), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check_flags("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("midrst_valid1", 32'(rd_valid1), 32'd0);
      check("midrst_data1", rd_data1, 32'd0);
      tick();
      check("midrst_valid2", 32'(rd_valid2), 32'd0);
      check("midrst_data2", rd_data2, 32'd0);
      rst = 1'b0;
      tick();
      check_flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/global_buffer_pingpong.md
Name: global_buffer_pingpong

Overview:
Two-bank ping-pong global buffer for streaming tiles between a producer and a consumer, such as a layer's output writer and the next layer's PE array. The producer fills one bank while the consumer drains the other. Ownership swaps through a done handshake on each side. Compared with the single-port BRAM buffer it adds independent write/read ports, per-byte write strobes, configurable read latency with a valid flag, and bank-state tracking with error flags.

Parameters:
ADDR_BITS, 8, address width per bank; each bank holds 2**ADDR_BITS entries.
DATA_BITS, 32, entry width; must be a multiple of 8.
READ_LAT, 1, read latency in cycles; legal values are 1 and 2 (2 adds an output register).

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request to the current write bank
wr_index  in  ADDR_BITS  write address
wr_data  in  DATA_BITS  write data
wr_strb  in  DATA_BITS/8  byte enables; bit i covers wr_data[8i+7:8i]
wr_done  in  1  producer finished the current write bank
wr_ready  out  1  current write bank is EMPTY and writable
wr_bank  out  1  index of the current write bank
rd_en  in  1  read request to the current read bank
rd_index  in  ADDR_BITS  read address
rd_done  in  1  consumer finished the current read bank
rd_ready  out  1  current read bank is FULL and readable
rd_bank  out  1  index of the current read bank
rd_data  out  DATA_BITS  read data
rd_valid  out  1  rd_data valid this cycle
wr_err  out  1  sticky: write-side request while !wr_ready
rd_err  out  1  sticky: read-side request while !rd_ready

Behaviour:
- State: per-bank status bit (EMPTY=0, FULL=1); pointers wbank and rbank.
- Reset values: both banks EMPTY, wbank=0, rbank=0, wr_ready=1, rd_ready=0, rd_valid=0, rd_data=0, wr_err=0, rd_err=0. Memory contents are not reset.
- wr_ready = (status[wbank]==EMPTY). rd_ready = (status[rbank]==FULL). Both are combinational from registers.
- Write: when wr_en && wr_ready, bytes with wr_strb set are written to bank[wbank][wr_index] at the clock edge. Other bytes are unchanged. wr_strb=0 writes nothing.
- wr_done && wr_ready: status[wbank] becomes FULL and wbank toggles, both at the same edge. If wr_en is asserted in the same cycle, that write commits to the closing bank.
- Read: rd_en && rd_ready samples bank[rbank][rd_index].
  - READ_LAT=1: rd_data and rd_valid update at the next edge.
  - READ_LAT=2: they update one cycle later.
  - Reads issue back-to-back, one per cycle.
  - rd_data holds its last value while rd_valid=0.
- rd_done && rd_ready: status[rbank] becomes EMPTY and rbank toggles. A read issued in the same cycle still returns data from the closing bank.
- wr_done and rd_done in the same cycle both take effect. They cannot target the same bank, because one side requires EMPTY and the other FULL.
- Requests without readiness:
  - wr_en or wr_done while !wr_ready is ignored (no memory or state change) and sets wr_err.
  - rd_en or rd_done while !rd_ready is ignored and sets rd_err.
  - Both flags are cleared only by rst.
- Both banks FULL: wr_ready=0, so the producer stalls. Both banks EMPTY: rd_ready=0, so the consumer stalls.
- Reset mid-operation: status bits, pointers, pipeline valids and error flags clear asynchronously, and in-flight reads are dropped (rd_valid=0). Memory keeps its data but is logically EMPTY.
- Each bank is inferred as block RAM (ram_style "block"): one write port and one read port per bank.

Test Plan:
1. Reset, then write 0x11223344 to bank0[5] with strb=4'hF, then wr_done -> wr_bank=1, rd_ready=1, rd_bank=0. rd_en at index 5 -> rd_valid one cycle later (READ_LAT=1) with rd_data=0x11223344.
2. Partial write: bank0[3]=0xAABBCCDD, then write 0x00000000 with strb=4'b0101, then close and read -> rd_data=0xAA00CC00.
3. Ping-pong concurrency: write bank1 while reading bank0 back-to-back at indices 0..255 -> 256 consecutive rd_valid cycles with correct data. Then assert wr_done and rd_done in the same cycle -> wr_bank=0, rd_bank=1, both flags clear.
4. Both FULL: close both banks without reading -> wr_ready=0. An extra wr_en leaves memory unchanged and sets wr_err=1. rd_en with both EMPTY after reset sets rd_err=1.
5. READ_LAT=2: reads at indices 7, 8, 9 in consecutive cycles -> rd_valid high for 3 cycles starting 2 cycles after the first request, with data in order.
6. Assert rst while rd_valid is pending and wr_bank=1 -> next cycle rd_valid=0, wr_bank=0, wr_ready=1, rd_ready=0, and both error flags are 0.
